// File: rtl/bch_31_dec_ctrl.sv
// bch_31_dec_ctrl: sequencing controller for the t=2 BCH(31,21) decoder.
//
// Accepts a received word and its syndromes, presents the syndromes to an
// external two-stage Berlekamp-Massey datapath, samples its locator
// coefficients, runs a serial 31-step Chien search and returns the corrected
// word with error status.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_ready             input handshake (ready only while idle)
//   in_data[30:0], in_S1..in_S4   received word (bit i = x^i) and syndromes
//   bm_S1..bm_S4                  registered syndromes to the BM datapath
//   bm_lambda1, bm_lambda2        locator coefficients from the BM datapath
//   out_valid/out_ready           output handshake
//   out_data[30:0]                corrected word, or raw word if uncorrectable
//   out_nerr[1:0], out_fail       corrected error count, uncorrectable flag
//
// Optional feature (macro BCH_DEC_STATS_EN): adds stat_words, stat_corr and
// stat_fail, 16-bit saturating counters of completed output handshakes.
module bch_31_dec_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [30:0] in_data,
  input  logic [4:0]  in_S1,
  input  logic [4:0]  in_S2,
  input  logic [4:0]  in_S3,
  input  logic [4:0]  in_S4,
  output logic [4:0]  bm_S1,
  output logic [4:0]  bm_S2,
  output logic [4:0]  bm_S3,
  output logic [4:0]  bm_S4,
  input  logic [4:0]  bm_lambda1,
  input  logic [4:0]  bm_lambda2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [30:0] out_data,
  output logic [1:0]  out_nerr,
  output logic        out_fail
`ifdef BCH_DEC_STATS_EN
  ,
  output logic [15:0] stat_words,
  output logic [15:0] stat_corr,
  output logic [15:0] stat_fail
`endif
);

  typedef enum logic [1:0] {StIdle, StBmWait, StChien, StDone} state_e;

  state_e      state_q, state_d;

  logic [30:0] data_q;
  logic [4:0]  s1_q, s2_q, s3_q, s4_q;
  logic [1:0]  wait_q;
  logic [4:0]  idx_q;
  logic [4:0]  t1_q, t2_q;
  logic [30:0] mask_q;
  logic [1:0]  roots_q;
  logic [1:0]  deg_q;

  logic        out_valid_q;
  logic [30:0] out_data_q;
  logic [1:0]  out_nerr_q;
  logic        out_fail_q;

  logic        accept, syn_zero, sample, step, last, fire;
  logic        lam_zero, is_root;
  logic [4:0]  lam1_eff, lam2_eff, cur_t1, cur_t2;
  logic        res_fail;
  logic [30:0] res_data;
  logic [1:0]  res_nerr;

  // Multiply by alpha^-1 = alpha^4 + alpha in GF(2^5), poly x^5+x^2+1.
  function automatic logic [4:0] mul_ainv(input logic [4:0] a);
    return {1'b0, a[4:1]} ^ (a[0] ? 5'b10010 : 5'b00000);
  endfunction

  // Datapath decode
  always_comb begin
    accept   = (state_q == StIdle) && in_valid;
    syn_zero = ~|{in_S1, in_S2, in_S3, in_S4};
    sample   = (state_q == StBmWait) && (wait_q == 2'd2);
    step     = sample || (state_q == StChien);
    last     = (state_q == StChien) && (idx_q == 5'd30);
    fire     = out_valid_q && out_ready;

    // A zero divisor in BM yields an all-zero locator; treat as single error.
    lam_zero = (bm_lambda1 == 5'd0) && (bm_lambda2 == 5'd0);
    lam1_eff = lam_zero ? s1_q : bm_lambda1;
    lam2_eff = lam_zero ? 5'd0 : bm_lambda2;

    // Position 0 is evaluated on the sampling edge straight from the locator.
    cur_t1   = sample ? lam1_eff : t1_q;
    cur_t2   = sample ? lam2_eff : t2_q;
    is_root  = ((5'd1 ^ cur_t1 ^ cur_t2) == 5'd0);

    res_fail = (roots_q != deg_q);
    res_data = res_fail ? data_q : (data_q ^ mask_q);
    res_nerr = res_fail ? 2'd0 : roots_q;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid) state_d = syn_zero ? StDone : StBmWait;
      StBmWait: if (sample) state_d = StChien;
      StChien:  if (last) state_d = StDone;
      StDone:   if (fire) state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = out_valid_q;
    out_data  = out_data_q;
    out_nerr  = out_nerr_q;
    out_fail  = out_fail_q;
    bm_S1     = s1_q;
    bm_S2     = s2_q;
    bm_S3     = s3_q;
    bm_S4     = s4_q;
  end

  // Word capture, BM wait and Chien search
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q  <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      s4_q    <= '0;
      wait_q  <= '0;
      idx_q   <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      mask_q  <= '0;
      roots_q <= '0;
      deg_q   <= '0;
    end else if (accept) begin
      data_q  <= in_data;
      s1_q    <= in_S1;
      s2_q    <= in_S2;
      s3_q    <= in_S3;
      s4_q    <= in_S4;
      wait_q  <= '0;
      idx_q   <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      mask_q  <= '0;
      roots_q <= '0;
      // deg 0 with no roots makes the clean-word path report no failure
      deg_q   <= '0;
    end else begin
      if ((state_q == StBmWait) && !sample) begin
        wait_q <= wait_q + 2'd1;
      end
      if (sample) begin
        deg_q <= (lam2_eff != 5'd0) ? 2'd2 : 2'd1;
      end
      if (step) begin
        t1_q  <= mul_ainv(cur_t1);
        t2_q  <= mul_ainv(mul_ainv(cur_t2));
        idx_q <= idx_q + 5'd1;
        if (is_root) begin
          mask_q  <= mask_q | (31'd1 << idx_q);
          roots_q <= (roots_q == 2'd3) ? 2'd3 : roots_q + 2'd1;
        end
      end
    end
  end

  // Result registers: loaded on the first DONE cycle, held until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_nerr_q  <= '0;
      out_fail_q  <= 1'b0;
    end else if ((state_q == StDone) && !out_valid_q) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res_data;
      out_nerr_q  <= res_nerr;
      out_fail_q  <= res_fail;
    end else if (fire) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef BCH_DEC_STATS_EN
  logic [15:0] stat_words_q, stat_corr_q, stat_fail_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_words_q <= '0;
      stat_corr_q  <= '0;
      stat_fail_q  <= '0;
    end else if (fire) begin
      if (stat_words_q != 16'hFFFF) stat_words_q <= stat_words_q + 16'd1;
      if ((out_nerr_q != 2'd0) && !out_fail_q && (stat_corr_q != 16'hFFFF)) begin
        stat_corr_q <= stat_corr_q + 16'd1;
      end
      if (out_fail_q && (stat_fail_q != 16'hFFFF)) begin
        stat_fail_q <= stat_fail_q + 16'd1;
      end
    end
  end

  assign stat_words = stat_words_q;
  assign stat_corr  = stat_corr_q;
  assign stat_fail  = stat_fail_q;
`endif

endmodule

// File: tb/tb_bch_31_dec_ctrl.sv
// Self-checking bench for bch_31_dec_ctrl: directed vector table, back-pressure
// and mid-operation reset sequences, then random error patterns checked
// against a polynomial-evaluation reference model. The bench also plays the
// external two-stage BM datapath.
module tb_bch_31_dec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [30:0] in_data;
  logic [4:0]  in_S1, in_S2, in_S3, in_S4;
  logic [4:0]  bm_S1, bm_S2, bm_S3, bm_S4;
  logic [4:0]  bm_lambda1, bm_lambda2;
  logic        out_valid;
  logic        out_ready;
  logic [30:0] out_data;
  logic [1:0]  out_nerr;
  logic        out_fail;
`ifdef BCH_DEC_STATS_EN
  logic [15:0] stat_words, stat_corr, stat_fail;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bch_31_dec_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_S1      (in_S1),
    .in_S2      (in_S2),
    .in_S3      (in_S3),
    .in_S4      (in_S4),
    .bm_S1      (bm_S1),
    .bm_S2      (bm_S2),
    .bm_S3      (bm_S3),
    .bm_S4      (bm_S4),
    .bm_lambda1 (bm_lambda1),
    .bm_lambda2 (bm_lambda2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_nerr   (out_nerr),
    .out_fail   (out_fail)
`ifdef BCH_DEC_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_corr  (stat_corr),
    .stat_fail  (stat_fail)
`endif
  );

  // GF(2^5) antilog/log tables, x^5+x^2+1
  int exp_t[31];
  int log_t[32];

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] + log_t[b]) % 31];
  endfunction

  function automatic int gdiv(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_t[(log_t[a] - log_t[b] + 31) % 31];
  endfunction

  // S_j = sum over error positions p of alpha^(j*p)
  function automatic int syn(input logic [30:0] e, input int j);
    int s = 0;
    for (int i = 0; i < 31; i++) if (e[i]) s = s ^ exp_t[(j * i) % 31];
    return s;
  endfunction

  // Closed-form t=2 BM result: lambda2 = (S3 + S1^3) / S1, zero on zero divisor
  function automatic int bm_l2(input int s1, input int s3);
    return gdiv(s3 ^ gmul(s1, gmul(s1, s1)), s1);
  endfunction

  // External BM datapath: result appears two edges after the syndromes.
  bit         force_zero = 1'b0;
  logic [4:0] p1_l1, p1_l2;
  always @(posedge clk) begin
    p1_l1      <= force_zero ? 5'd0 : bm_S1;
    p1_l2      <= force_zero ? 5'd0 : 5'(bm_l2(int'(bm_S1), int'(bm_S3)));
    bm_lambda1 <= p1_l1;
    bm_lambda2 <= p1_l2;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: evaluate the locator at every alpha^-i and apply the decision rules.
  task automatic model(input logic [30:0] recv, input logic [30:0] err, input bit fz,
                       output logic [30:0] ed, output logic [1:0] en, output bit ef,
                       output int el);
    int s1, s2, s3, s4, l1, l2, deg, roots, x;
    logic [30:0] mask;
    s1 = syn(err, 1); s2 = syn(err, 2); s3 = syn(err, 3); s4 = syn(err, 4);
    if ((s1 | s2 | s3 | s4) == 0) begin
      ed = recv; en = 2'd0; ef = 1'b0; el = 1;
    end else begin
      l1 = fz ? 0 : s1;
      l2 = fz ? 0 : bm_l2(s1, s3);
      if (l1 == 0 && l2 == 0) begin
        l1 = s1;
        l2 = 0;
      end
      deg   = (l2 != 0) ? 2 : 1;
      roots = 0;
      mask  = '0;
      for (int i = 0; i < 31; i++) begin
        x = exp_t[(31 - i) % 31];
        if ((1 ^ gmul(l1, x) ^ gmul(l2, gmul(x, x))) == 0) begin
          mask[i] = 1'b1;
          if (roots < 3) roots++;
        end
      end
      ef = (roots != deg);
      ed = ef ? recv : (recv ^ mask);
      en = ef ? 2'd0 : 2'(roots);
      el = 34;
    end
  endtask

  // One full transaction from IDLE; returns latency and the presented result.
  task automatic run_word(input logic [30:0] recv, input logic [30:0] err, input bit fz,
                          input bit hold, output int lat, output logic [30:0] od,
                          output logic [1:0] on, output logic of);
    logic [19:0] s_exp;
    s_exp      = {5'(syn(err, 1)), 5'(syn(err, 2)), 5'(syn(err, 3)), 5'(syn(err, 4))};
    force_zero = fz;
    in_data    = recv;
    {in_S1, in_S2, in_S3, in_S4} = s_exp;
    out_ready  = hold;
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bm_syn", {bm_S1, bm_S2, bm_S3, bm_S4}, s_exp);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    od = out_data;
    on = out_nerr;
    of = out_fail;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("handshake", {out_valid, in_ready}, 2'b01);
  endtask

  typedef struct {
    logic [30:0] recv;
    logic [30:0] err;
    bit          fz;
    logic [30:0] ed;
    logic [1:0]  en;
    bit          ef;
    int          el;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int          v, lat, ne;
    logic [30:0] od, ed, c, err, recv;
    logic [1:0]  on, en;
    logic        of;
    bit          ef, fz, seen;
    int          el;

    v = 1;
    for (int k = 0; k < 31; k++) begin
      exp_t[k] = v;
      log_t[v] = k;
      v = v << 1;
      if ((v & 32) != 0) v = v ^ 37;
    end
    log_t[0] = 0;

    //          recv           err            fz  exp data       nerr  fail lat
    vecs[0] = '{31'h12345678, 31'h00000000, 0, 31'h12345678, 2'd0, 0, 1};
    vecs[1] = '{31'h00000080, 31'h00000080, 1, 31'h00000000, 2'd1, 0, 34};
    vecs[2] = '{31'h00100008, 31'h00100008, 0, 31'h00000000, 2'd2, 0, 34};
    vecs[3] = '{31'h00000007, 31'h00000007, 0, 31'h00000007, 2'd0, 1, 34};
    vecs[4] = '{31'h2AAAAAAB, 31'h00000001, 0, 31'h2AAAAAAA, 2'd1, 0, 34};
    vecs[5] = '{31'h4F0F0F0F, 31'h40000000, 1, 31'h0F0F0F0F, 2'd1, 0, 34};
    vecs[6] = '{31'h3FFFFFFE, 31'h40000001, 0, 31'h7FFFFFFF, 2'd2, 0, 34};

    rst = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    {in_S1, in_S2, in_S3, in_S4} = '0;
    out_ready = 1'b0;

    #12;
    chk("rst_flags", {out_valid, out_nerr, out_fail}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_bm", {bm_S1, bm_S2, bm_S3, bm_S4}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      run_word(vecs[i].recv, vecs[i].err, vecs[i].fz, (i % 2) == 1, lat, od, on, of);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].el);
      chk($sformatf("vec%0d_data", i), od, vecs[i].ed);
      chk($sformatf("vec%0d_nerr", i), on, vecs[i].en);
      chk($sformatf("vec%0d_fail", i), of, vecs[i].ef);
`ifdef BCH_DEC_STATS_EN
      if (i == 3) begin
        chk("stat_words", stat_words, 4);
        chk("stat_corr", stat_corr, 2);
        chk("stat_fail", stat_fail, 1);
      end
`endif
    end

    // Back-pressure, with in_valid and junk inputs held while busy
    force_zero = 1'b0;
    in_data = vecs[2].recv;
    in_S1 = 5'(syn(vecs[2].err, 1));
    in_S2 = 5'(syn(vecs[2].err, 2));
    in_S3 = 5'(syn(vecs[2].err, 3));
    in_S4 = 5'(syn(vecs[2].err, 4));
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_data = 31'h7FFF0000;
    in_S1 = 5'h1F; in_S2 = 5'h03; in_S3 = 5'h09; in_S4 = 5'h11;
    chk("bp_busy_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_lat", lat, 34);
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bp_hold", {out_valid, in_ready, out_fail, out_nerr, out_data},
          {1'b1, 1'b0, 1'b0, 2'd2, 31'd0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    // Reset during the Chien search aborts the word
    in_data = vecs[3].recv;
    in_S1 = 5'(syn(vecs[3].err, 1));
    in_S2 = 5'(syn(vecs[3].err, 2));
    in_S3 = 5'(syn(vecs[3].err, 3));
    in_S4 = 5'(syn(vecs[3].err, 4));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_out", {out_valid, out_nerr, out_fail, out_data}, 0);
    chk("midrst_bm", {bm_S1, bm_S2, bm_S3, bm_S4}, 0);
    chk("midrst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);
    run_word(vecs[2].recv, vecs[2].err, vecs[2].fz, 1'b0, lat, od, on, of);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_data", od, 0);
    chk("post_rst_nerr", on, 2);
    chk("post_rst_fail", of, 0);

    // Random error patterns of weight 0..3
    for (int k = 0; k < 24; k++) begin
      ne  = $urandom_range(0, 3);
      err = '0;
      while ($countones(err) < ne) err[$urandom_range(0, 30)] = 1'b1;
      c    = 31'($urandom);
      recv = c ^ err;
      fz   = (ne == 1) && ($urandom_range(0, 1) == 1);
      model(recv, err, fz, ed, en, ef, el);
      run_word(recv, err, fz, $urandom_range(0, 1) == 1, lat, od, on, of);
      chk($sformatf("rnd%0d_lat", k), lat, el);
      chk($sformatf("rnd%0d_data", k), od, ed);
      chk($sformatf("rnd%0d_nerr", k), on, en);
      chk($sformatf("rnd%0d_fail", k), of, ef);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
